// File: rtl/test_runner.sv
// Test sequencer: walks an enable mask, launches each selected test in turn,
// bounds it with a cycle timeout and aggregates an overall verdict.
module test_runner #(
    parameter int unsigned N_TESTS = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_TESTS-1:0] enable_mask,
    output logic [N_TESTS-1:0] test_start,
    input  logic [N_TESTS-1:0] test_done,
    input  logic [N_TESTS-1:0] test_pass,
    output logic               busy,
    output logic               done,
    output logic               all_pass,
    output logic [IDX_W-1:0]   current_test,
    output logic [N_TESTS-1:0] result_pass,
    output logic [N_TESTS-1:0] result_timeout,
    output logic [IDX_W:0]     pass_count,
    output logic [IDX_W:0]     fail_count
);

    localparam int unsigned CW = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t             r_state;
    logic [N_TESTS-1:0] r_mask;
    logic [CNT_W-1:0]   r_cnt;

    logic w_done_hit;
    logic w_pass_bit;
    logic w_timeout;
    logic w_last;
    logic w_record;
    logic w_rec_fail;

    // Only the awaited channel's strobe matters; done beats an expiring timeout.
    assign w_done_hit = test_done[current_test];
    assign w_pass_bit = test_pass[current_test];
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_last     = (current_test == IDX_W'(N_TESTS - 1));
    assign w_record   = w_done_hit || w_timeout;
    assign w_rec_fail = w_done_hit ? !w_pass_bit : w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_mask         <= '0;
            r_cnt          <= '0;
            test_start     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            all_pass       <= 1'b0;
            current_test   <= '0;
            result_pass    <= '0;
            result_timeout <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
        end else begin
            test_start <= '0;
            done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask         <= enable_mask;
                        result_pass    <= '0;
                        result_timeout <= '0;
                        pass_count     <= '0;
                        fail_count     <= '0;
                        all_pass       <= 1'b0;
                        current_test   <= '0;
                        busy           <= 1'b1;
                        r_state        <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_mask[current_test]) begin
                        test_start <= N_TESTS'(1) << current_test;
                        r_state    <= S_LAUNCH;
                    end else if (w_last) begin
                        done     <= 1'b1;
                        all_pass <= (fail_count == '0);
                        r_state  <= S_FINISH;
                    end else begin
                        current_test <= current_test + IDX_W'(1);
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_record) begin
                        if (w_done_hit) begin
                            result_pass[current_test] <= w_pass_bit;
                        end else begin
                            result_timeout[current_test] <= 1'b1;
                        end
                        if (w_rec_fail) begin
                            fail_count <= fail_count + CW'(1);
                        end else begin
                            pass_count <= pass_count + CW'(1);
                        end
                        if (w_last) begin
                            done     <= 1'b1;
                            all_pass <= (fail_count == '0) && !w_rec_fail;
                            r_state  <= S_FINISH;
                        end else begin
                            current_test <= current_test + IDX_W'(1);
                            r_state      <= S_SCAN;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_runner.sv
// Bench for test_runner: a run-level model expands each run (mask, per-test
// response cycle) into an expected per-cycle trace that is replayed and compared.
module tb_test_runner;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [N-1:0]  enable_mask, test_start, test_done, test_pass;
    logic [N-1:0]  result_pass, result_timeout;
    logic          busy, done, all_pass;
    logic [IW-1:0] current_test;
    logic [IW:0]   pass_count, fail_count;

    always #5 clk = ~clk;

    test_runner #(.N_TESTS(N), .IDX_W(IW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .enable_mask(enable_mask),
        .test_start(test_start), .test_done(test_done), .test_pass(test_pass),
        .busy(busy), .done(done), .all_pass(all_pass), .current_test(current_test),
        .result_pass(result_pass), .result_timeout(result_timeout),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    typedef struct packed {
        logic          rst;
        logic          st;
        logic          acc;
        logic [N-1:0]  mask;
        logic [N-1:0]  tdone;
        logic [N-1:0]  tpass;
        logic [N-1:0]  ts;
        logic [N-1:0]  rp;
        logic [N-1:0]  rt;
        logic          bsy;
        logic          dn;
        logic          ap;
        logic [IW-1:0] cur;
        logic [IW:0]   pc;
        logic [IW:0]   fc;
    } cyc_t;

    cyc_t q[$];

    // Model of the externally visible held results.
    logic [N-1:0]  m_rp, m_rt;
    logic [IW:0]   m_pc, m_fc;
    logic          m_all;
    logic [IW-1:0] m_cur;

    int g_cnt, g_rst_at;
    bit g_ab;
    int g_wd[N];
    int n_vec, n_mis;
    int lat_ts, lat_done, since;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] noise(input int excl);
        logic [N-1:0] v;
        v = N'($urandom);
        if (excl >= 0) v = v & ~(N'(1) << excl);
        return v;
    endfunction

    function automatic logic rstart(input bit rs);
        return rs ? 1'($urandom) : 1'b0;
    endfunction

    task automatic model_clear();
        m_rp = '0; m_rt = '0; m_pc = '0; m_fc = '0; m_all = 1'b0; m_cur = '0;
    endtask

    task automatic emit(input logic st, input logic acc, input logic [N-1:0] mask,
                        input logic [N-1:0] td, input logic [N-1:0] tp,
                        input logic [N-1:0] ts, input logic bsy, input logic dn);
        cyc_t e;
        e.rst = 1'b0; e.st = st; e.acc = acc; e.mask = mask; e.tdone = td; e.tpass = tp;
        e.ts = ts; e.rp = m_rp; e.rt = m_rt; e.bsy = bsy; e.dn = dn; e.ap = m_all;
        e.cur = m_cur; e.pc = m_pc; e.fc = m_fc;
        if (g_rst_at >= 0 && g_cnt == g_rst_at) begin
            e.rst = 1'b1;
            g_ab  = 1'b1;
        end
        q.push_back(e);
        g_cnt++;
        if (g_ab) model_clear();
    endtask

    task automatic gen_idle(input int n, input bit go, input logic [N-1:0] mask);
        for (int i = 0; i < n; i++) begin
            logic s;
            s = go && (i == n - 1);
            emit(s, s, s ? mask : noise(-1), noise(-1), noise(-1), '0, 1'b0, 1'b0);
        end
    endtask

    // One run, starting with the first cycle after the accepted start edge.
    task automatic gen_run(input logic [N-1:0] mask, input logic [N-1:0] pv,
                           input bit rs, input int rst_at, input bit glitch);
        g_cnt = 0; g_rst_at = rst_at; g_ab = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) begin
            m_cur = IW'(i);
            emit(rstart(rs), 1'b0, noise(-1), noise(-1), noise(-1), '0, 1'b1, 1'b0);
            if (g_ab) return;
            if (mask[i]) begin
                int len;
                bit hit;
                hit = (g_wd[i] >= 0) && (g_wd[i] < int'(TO));
                len = hit ? g_wd[i] + 1 : int'(TO);
                emit(rstart(rs), 1'b0, noise(-1),
                     noise(-1) | (glitch ? (N'(1) << i) : N'(0)), noise(-1),
                     N'(1) << i, 1'b1, 1'b0);
                if (g_ab) return;
                for (int w = 0; w < len; w++) begin
                    logic [N-1:0] td, tp;
                    td = noise(i);
                    tp = noise(-1);
                    if (hit && w == g_wd[i]) begin
                        td = td | (N'(1) << i);
                        tp = pv[i] ? (tp | (N'(1) << i)) : (tp & ~(N'(1) << i));
                    end
                    emit(rstart(rs), 1'b0, noise(-1), td, tp, '0, 1'b1, 1'b0);
                    if (g_ab) return;
                end
                if (hit) begin
                    if (pv[i]) begin
                        m_rp = m_rp | (N'(1) << i);
                        m_pc = m_pc + 1'b1;
                    end else begin
                        m_fc = m_fc + 1'b1;
                    end
                end else begin
                    m_rt = m_rt | (N'(1) << i);
                    m_fc = m_fc + 1'b1;
                end
            end
        end
        m_all = (m_fc == '0);
        emit(rstart(rs), 1'b0, noise(-1), noise(-1), noise(-1), '0, 1'b1, 1'b1);
    endtask

    task automatic run(input logic [N-1:0] mask, input logic [N-1:0] pv, input bit rs,
                       input int rst_at, input bit glitch, input int pre);
        gen_idle(pre, 1'b1, mask);
        gen_run(mask, pv, rs, rst_at, glitch);
        g_rst_at = -1;
        gen_idle(2, 1'b0, '0);
    endtask

    // Replays the trace: compare outputs, then drive the cycle's inputs.
    task automatic play();
        while (q.size() > 0) begin
            cyc_t e;
            e = q.pop_front();
            @(negedge clk);
            if (e.acc) begin
                since = 0; lat_ts = -1; lat_done = -1;
            end else begin
                since++;
            end
            if (test_start != '0 && lat_ts < 0) lat_ts = since;
            if (done && lat_done < 0) lat_done = since;
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("done", 32'(done), 32'(e.dn));
            chk("all_pass", 32'(all_pass), 32'(e.ap));
            chk("test_start", 32'(test_start), 32'(e.ts));
            chk("current_test", 32'(current_test), 32'(e.cur));
            chk("result_pass", 32'(result_pass), 32'(e.rp));
            chk("result_timeout", 32'(result_timeout), 32'(e.rt));
            chk("pass_count", 32'(pass_count), 32'(e.pc));
            chk("fail_count", 32'(fail_count), 32'(e.fc));
            reset       = e.rst;
            start       = e.st;
            enable_mask = e.mask;
            test_done   = e.tdone;
            test_pass   = e.tpass;
        end
    endtask

    task automatic set_wd(input int a, input int b, input int c, input int d);
        g_wd[0] = a; g_wd[1] = b; g_wd[2] = c; g_wd[3] = d;
    endtask

    initial begin
        n_vec = 0; n_mis = 0; since = 0; lat_ts = -1; lat_done = -1;
        reset = 1'b1; start = 1'b0; enable_mask = '0; test_done = '0; test_pass = '0;
        g_rst_at = -1; g_cnt = 0; g_ab = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_all_pass", 32'(all_pass), 32'd0);
        chk("rst_test_start", 32'(test_start), 32'd0);
        chk("rst_pass_count", 32'(pass_count), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);

        // All four tests pass three cycles after launch.
        set_wd(2, 2, 2, 2);
        run(4'b1111, 4'b1111, 1'b0, -1, 1'b0, 2);
        play();
        chk("p1_launch_lat", 32'(lat_ts), 32'd2);
        chk("p1_done_lat", 32'(lat_done), 32'd21);
        chk("p1_pass_count", 32'(pass_count), 32'd4);
        chk("p1_all_pass", 32'(all_pass), 32'd1);
        chk("p1_result_pass", 32'(result_pass), 32'hf);

        // Test 2 reports a failure.
        set_wd(1, 0, 4, 0);
        run(4'b0101, 4'b0001, 1'b0, -1, 1'b0, 1);
        play();
        chk("p2_result_pass", 32'(result_pass), 32'h1);
        chk("p2_pass_count", 32'(pass_count), 32'd1);
        chk("p2_fail_count", 32'(fail_count), 32'd1);
        chk("p2_all_pass", 32'(all_pass), 32'd0);

        // Test 1 never responds.
        set_wd(0, -1, 0, 0);
        run(4'b0010, 4'b1111, 1'b0, -1, 1'b0, 1);
        play();
        chk("p3_result_timeout", 32'(result_timeout), 32'h2);
        chk("p3_fail_count", 32'(fail_count), 32'd1);
        chk("p3_done_lat", 32'(lat_done), 32'd22);

        // Strobe during LAUNCH ignored; strobe on the last WAIT cycle beats timeout.
        set_wd(15, 0, 0, 0);
        run(4'b0001, 4'b0001, 1'b0, -1, 1'b1, 3);
        play();
        chk("p4_result_timeout", 32'(result_timeout), 32'h0);
        chk("p4_result_pass", 32'(result_pass), 32'h1);
        chk("p4_all_pass", 32'(all_pass), 32'd1);

        // Reset in the first WAIT cycle of test 2, then an empty-mask run.
        set_wd(1, 1, 1, 1);
        run(4'b1111, 4'b1111, 1'b0, 10, 1'b0, 1);
        play();
        chk("p5_no_done", 32'(lat_done), 32'hffffffff);
        chk("p5_pass_count", 32'(pass_count), 32'd0);
        chk("p5_result_pass", 32'(result_pass), 32'h0);
        run(4'b0000, 4'b1111, 1'b0, -1, 1'b0, 1);
        play();
        chk("p5_done_lat", 32'(lat_done), 32'd5);
        chk("p5_all_pass", 32'(all_pass), 32'd1);

        // start held/toggling and mask changing during the run; back-to-back runs.
        set_wd(0, 3, 1, 2);
        gen_idle(1, 1'b1, 4'b1011);
        gen_run(4'b1011, 4'b1001, 1'b1, -1, 1'b0);
        g_rst_at = -1;
        set_wd(2, 1, 0, -1);
        run(4'b1100, 4'b0100, 1'b1, -1, 1'b0, 1);
        play();
        chk("p6_result_timeout", 32'(result_timeout), 32'h8);
        chk("p6_result_pass", 32'(result_pass), 32'h4);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < int'(N); i++) begin
                int p;
                p = int'($urandom_range(0, 9));
                g_wd[i] = (p < 2) ? -1 : (p == 2) ? int'(TO) - 1 : int'($urandom_range(0, 5));
            end
            run(N'($urandom), N'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 30)) : -1,
                1'($urandom), int'($urandom_range(1, 3)));
            play();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/test_runner.md
Name: test_runner

Overview:
Parametrised, synthesizable test sequencer that replaces hand-editing of the simulation top, where individual tests are commented in and out. It launches up to N_TESTS component or instruction test channels one at a time under a runtime enable mask, and bounds each test with a cycle timeout. It aggregates pass, fail and timeout results and reports a single overall verdict. It sits in the simulation top between the clock generator and the per-test modules.

Parameters:
N_TESTS, 8, number of test channels.
IDX_W, 3, width of the test index; must satisfy 2^IDX_W >= N_TESTS.
TIMEOUT, 1024, maximum WAIT cycles allowed per test before it is declared timed out; must be >= 1.
CNT_W, 16, width of the WAIT cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a run; sampled only in IDLE.
enable_mask  in  N_TESTS  bit i=1 selects test i; latched on an accepted start.
test_start  out  N_TESTS  one-hot, single-cycle launch pulse to the selected test.
test_done  in  N_TESTS  test i completion strobe.
test_pass  in  N_TESTS  test i verdict; valid when test_done[i]=1.
busy  out  1  high from the cycle after an accepted start until FINISH completes.
done  out  1  single-cycle pulse at the end of a run.
all_pass  out  1  valid from done onward: fail_count==0.
current_test  out  IDX_W  index of the test being launched or awaited.
result_pass  out  N_TESTS  per-test pass flags.
result_timeout  out  N_TESTS  per-test timeout flags.
pass_count  out  IDX_W+1  number of tests that passed.
fail_count  out  IDX_W+1  number of failures, timeouts included.

Behaviour:
- Reset: FSM goes to IDLE. All outputs 0, including all_pass and the internal latched mask and counter. Reset asserted mid-run aborts the run immediately: no done pulse, no test_start pulse in the following cycle.
- FSM states: IDLE, SCAN, LAUNCH, WAIT, FINISH.
- IDLE: when start=1, latch enable_mask and clear the results and counts. Go to SCAN with current_test=0.
- SCAN (one cycle per index): if mask[current_test]=1, go to LAUNCH. Otherwise, if current_test==N_TESTS-1, go to FINISH; else increment current_test and stay in SCAN.
- LAUNCH (one cycle): test_start[current_test]=1 and all other bits 0. Clear the counter. Go to WAIT.
- WAIT: sample only test_done[current_test] and ignore all other bits. test_done asserted during the LAUNCH cycle is ignored.
  - On done: set result_pass[idx]=test_pass[idx]. Increment pass_count or fail_count accordingly.
  - If no done and the counter equals TIMEOUT-1: set result_timeout[idx]=1 and increment fail_count.
  - Otherwise increment the counter.
  - Done and timeout in the same cycle: done wins.
  - After recording, if idx==N_TESTS-1 go to FINISH; else increment current_test and go to SCAN.
- FINISH (one cycle): done=1 and all_pass=(fail_count==0). Return to IDLE. busy drops in the cycle after FINISH.
- Results and counts hold their values until the next accepted start.
- start while not IDLE is ignored; it is not queued.
- start and done pulse coinciding: the start is ignored because the FSM is still in FINISH.
- enable_mask changes after start have no effect on the current run.
- All-zero mask: SCAN walks every index, then FINISH. done occurs N_TESTS+1 cycles after the start edge, with all_pass=1 and both counts 0.
- Timing: start accepted at edge k gives test_start high in cycle k+2 (SCAN, then LAUNCH).

Test Plan:
1. N_TESTS=4, TIMEOUT=16, mask=4'b1111. Each test returns done with pass=1 three cycles after its launch -> four one-hot test_start pulses in index order 0,1,2,3. pass_count=4, fail_count=0, all_pass=1, done pulse exactly one cycle.
2. mask=4'b0101; test 2 returns pass=0 -> no launch pulses for tests 1 or 3. result_pass=4'b0001, pass_count=1, fail_count=1, all_pass=0.
3. mask=4'b0010; test 1 never asserts done -> result_timeout=4'b0010 after exactly 16 WAIT cycles, fail_count=1, then done pulse.
4. Test 0 asserts done during LAUNCH and again on WAIT cycle 15 (counter==TIMEOUT-1) -> the LAUNCH-cycle strobe is ignored. The WAIT strobe wins over timeout: result_timeout[0]=0, pass recorded.
5. Mid-run: reset during the WAIT of test 2 -> next cycle all outputs 0 and no done pulse. A following start with mask=4'b0000 -> done 5 cycles after the start edge, all_pass=1.
6. start held high through a whole run, and enable_mask toggled mid-run -> exactly one run executes, using the latched mask. A second run begins only from IDLE after the done pulse.
